// File: rtl/map_checkpoint_buffer_pkg.sv
// Shared rename types: default sizing and the map-snapshot / checkpoint-id types
// used by the map table and the checkpoint buffer.
package rename_pkg;

    localparam int unsigned DFLT_ARCH_REGS = 64;
    localparam int unsigned DFLT_PHYS_REGS = 128;
    localparam int unsigned DFLT_NUM_CKPT  = 8;

    localparam int unsigned PTAG_W = $clog2(DFLT_PHYS_REGS);
    localparam int unsigned CK_W   = $clog2(DFLT_NUM_CKPT);

    typedef logic [DFLT_ARCH_REGS-1:0][PTAG_W-1:0] map_snapshot_t;
    typedef logic [CK_W-1:0]                       ckpt_id_t;

endpackage

// File: rtl/map_checkpoint_buffer_snapshot_ram.sv
// Snapshot storage: one write port, one synchronous read port whose output
// register is the restore data seen by the map table.
module ckpt_snapshot_ram
    import rename_pkg::*;
#(
    parameter int unsigned DEPTH  = DFLT_NUM_CKPT,
    parameter int unsigned WIDTH  = DFLT_ARCH_REGS * PTAG_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Array contents are not reset; only the read register is.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register loads only on a read request, otherwise holds.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // Read data register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/map_checkpoint_buffer.sv
// Circular buffer of rename-map checkpoints, one per in-flight branch.
// Captures snapshots on dispatch, restores on mispredict, retires in order.
module map_checkpoint_buffer
    import rename_pkg::*;
#(
    parameter int unsigned ARCH_REGS = DFLT_ARCH_REGS,
    parameter int unsigned PHYS_REGS = DFLT_PHYS_REGS,
    parameter int unsigned NUM_CKPT  = DFLT_NUM_CKPT,
    localparam int unsigned TAG_W    = $clog2(PHYS_REGS),
    localparam int unsigned ID_W     = $clog2(NUM_CKPT)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             alloc_valid_i,
    input  logic [ARCH_REGS-1:0][TAG_W-1:0]  alloc_snapshot_i,
    output logic                             alloc_ready_o,
    output logic [ID_W-1:0]                  alloc_id_o,
    input  logic                             resolve_valid_i,
    input  logic [ID_W-1:0]                  resolve_id_i,
    input  logic                             resolve_mispredict_i,
    input  logic                             flush_i,
    output logic                             restore_valid_o,
    output logic [ARCH_REGS-1:0][TAG_W-1:0]  restore_data_o,
    output logic [ID_W-1:0]                  restore_id_o,
    output logic [ID_W:0]                    count_o,
    output logic                             empty_o
);

    logic [ID_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [ID_W-1:0]     restore_id_q, restore_id_d;
    logic [ID_W:0]       count_q, count_d;
    logic [NUM_CKPT-1:0] valid_q, valid_d, resolved_q, resolved_d;
    logic                restore_valid_q, restore_valid_d;
    logic                fire, mispredict, retire, ram_rd_en;
    logic [ID_W-1:0]     mis_dist;

    // Handshake and event decode for this cycle.
    always_comb begin
        alloc_ready_o = reset && !flush_i && (count_q < (ID_W+1)'(NUM_CKPT))
                        && !(resolve_valid_i && resolve_mispredict_i);
        fire          = alloc_valid_i && alloc_ready_o;
        mispredict    = resolve_valid_i && resolve_mispredict_i && valid_q[resolve_id_i];
        // Head may still retire under a mispredict unless head itself is being restored.
        retire        = valid_q[head_q] && resolved_q[head_q]
                        && !(mispredict && (head_q == resolve_id_i));
        mis_dist      = resolve_id_i - head_q;
        ram_rd_en     = mispredict && !flush_i;
    end

    // Next-state: flush over mispredict over retire/resolve/alloc.
    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        valid_d         = valid_q;
        resolved_d      = resolved_q;
        restore_valid_d = 1'b0;
        restore_id_d    = restore_id_q;

        if (retire) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = head_q + 1'b1;
        end

        if (resolve_valid_i && !resolve_mispredict_i && valid_q[resolve_id_i]) begin
            resolved_d[resolve_id_i] = 1'b1;
        end

        if (mispredict) begin
            // Age is distance from head, so squash covers id..tail-1 across the wrap.
            for (int unsigned s = 0; s < NUM_CKPT; s++) begin
                if ((ID_W'(s) - head_q) >= mis_dist) begin
                    valid_d[s]    = 1'b0;
                    resolved_d[s] = 1'b0;
                end
            end
            tail_d          = resolve_id_i;
            count_d         = {1'b0, mis_dist} - (ID_W+1)'(retire);
            restore_valid_d = 1'b1;
            restore_id_d    = resolve_id_i;
        end else begin
            if (fire) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                tail_d             = tail_q + 1'b1;
            end
            count_d = count_q + (ID_W+1)'(fire) - (ID_W+1)'(retire);
        end

        if (flush_i) begin
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
            valid_d         = '0;
            resolved_d      = '0;
            restore_valid_d = 1'b0;
            restore_id_d    = restore_id_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            valid_q         <= '0;
            resolved_q      <= '0;
            restore_valid_q <= 1'b0;
            restore_id_q    <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            valid_q         <= valid_d;
            resolved_q      <= resolved_d;
            restore_valid_q <= restore_valid_d;
            restore_id_q    <= restore_id_d;
        end
    end

    ckpt_snapshot_ram #(
        .DEPTH (NUM_CKPT),
        .WIDTH (ARCH_REGS * TAG_W)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (fire),
        .wr_addr_i (tail_q),
        .wr_data_i (alloc_snapshot_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (resolve_id_i),
        .rd_data_o (restore_data_o)
    );

    assign alloc_id_o      = tail_q;
    assign restore_valid_o = restore_valid_q;
    assign restore_id_o    = restore_id_q;
    assign count_o         = count_q;
    assign empty_o         = (count_q == '0);

endmodule
